// File: rtl/hack_cpu_seq_if.sv
// Signal bundle between the Hack CPU sequencer and its ROM, RAM, ALU and A-input mux.
// master = sequencer side, slave = memories/datapath side.
interface hack_cpu_seq_if;
  logic        instr_req;
  logic [14:0] instr_addr;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] ir;
  logic        mux_sel;
  logic [15:0] mux_out;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctrl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [14:0] addressM;
  logic        readM;
  logic        writeM;
  logic [15:0] outM;
  logic [15:0] inM;
  logic        mem_ack;

  modport master (
    output instr_req, instr_addr, ir, mux_sel, alu_x, alu_y, alu_ctrl,
           addressM, readM, writeM, outM,
    input  instr_valid, instr, mux_out, alu_out, alu_zr, alu_ng, inM, mem_ack
  );

  modport slave (
    input  instr_req, instr_addr, ir, mux_sel, alu_x, alu_y, alu_ctrl,
           addressM, readM, writeM, outM,
    output instr_valid, instr, mux_out, alu_out, alu_zr, alu_ng, inM, mem_ack
  );
endinterface

// File: rtl/hack_cpu_seq.sv
// Hack CPU multi-cycle sequencer: PC/IR/A/D/M-latch plus FETCH-DECODE-MEMRD-EXEC-WB control.
// Strobes are registered from the next state, so they change exactly on the state transition edge.
module hack_cpu_seq #(
  parameter logic [14:0] PC_RESET = 15'h0000
) (
  input logic            clk,
  input logic            reset,
  hack_cpu_seq_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, MEMRD, EXEC, WB} state_t;

  state_t      state_q, state_d;
  logic [14:0] pc_q, pc_d, waddr_q, waddr_d;
  logic [15:0] ir_q, ir_d, a_q, a_d, d_q, d_d, m_q, m_d, wdata_q, wdata_d;
  logic        instr_req_q, instr_req_d, read_m_q, read_m_d;
  logic        write_m_q, write_m_d, mux_sel_q, mux_sel_d;
  logic [14:0] pc_inc;
  logic        jump;

  assign pc_inc = pc_q + 15'd1;
  assign jump   = (ir_q[2] & bus.alu_ng) | (ir_q[1] & bus.alu_zr) |
                  (ir_q[0] & ~bus.alu_ng & ~bus.alu_zr);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    d_d     = d_q;
    m_d     = m_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!ir_q[15]) begin
          a_d     = bus.mux_out;
          pc_d    = pc_inc;
          state_d = FETCH;
        end else begin
          state_d = ir_q[12] ? MEMRD : EXEC;
        end
      end
      MEMRD: begin
        if (bus.mem_ack) begin
          m_d     = bus.inM;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (ir_q[5]) a_d = bus.mux_out;
        if (ir_q[4]) d_d = bus.alu_out;
        if (ir_q[3]) begin
          waddr_d = a_q[14:0];
          wdata_d = bus.alu_out;
        end
        // Jump target and write address both use A as it was before this edge.
        pc_d    = jump ? a_q[14:0] : pc_inc;
        state_d = ir_q[3] ? WB : FETCH;
      end
      WB: begin
        if (bus.mem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    instr_req_d = (state_d == FETCH);
    read_m_d    = (state_d == MEMRD);
    write_m_d   = (state_d == WB);
    mux_sel_d   = (state_d == EXEC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= PC_RESET;
      ir_q        <= 16'h0000;
      a_q         <= 16'h0000;
      d_q         <= 16'h0000;
      m_q         <= 16'h0000;
      waddr_q     <= 15'h0000;
      wdata_q     <= 16'h0000;
      instr_req_q <= 1'b1;
      read_m_q    <= 1'b0;
      write_m_q   <= 1'b0;
      mux_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      d_q         <= d_d;
      m_q         <= m_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      instr_req_q <= instr_req_d;
      read_m_q    <= read_m_d;
      write_m_q   <= write_m_d;
      mux_sel_q   <= mux_sel_d;
    end
  end

  assign bus.instr_req  = instr_req_q;
  assign bus.instr_addr = pc_q;
  assign bus.ir         = ir_q;
  assign bus.mux_sel    = mux_sel_q;
  assign bus.alu_x      = d_q;
  assign bus.alu_y      = ir_q[12] ? m_q : a_q;
  assign bus.alu_ctrl   = ir_q[11:6];
  assign bus.readM      = read_m_q;
  assign bus.writeM     = write_m_q;
  assign bus.addressM   = write_m_q ? waddr_q : a_q[14:0];
  assign bus.outM       = write_m_q ? wdata_q : 16'h0000;
endmodule

// File: tb/tb_hack_cpu_seq.sv
// Bench for hack_cpu_seq: ROM/RAM/ALU/mux environment plus an instruction-level Hack reference model.
module tb_hack_cpu_seq;
  localparam logic [14:0] PC_RST = 15'h0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  hack_cpu_seq_if bus ();
  hack_cpu_seq #(.PC_RESET(PC_RST)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] pc;
    logic [14:0] a;
    logic [15:0] d;
    logic [15:0] y;
    logic [15:0] ir;
    int          cyc;
    int          stalls;
  } fetch_t;
  typedef struct {
    logic [14:0] addr;
    logic [15:0] dat;
  } mem_t;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, stall_cnt = 0, wr_cycles = 0, wait_pct = 0;
  bit ack_block = 1'b0;
  fetch_t      fetch_q[$];
  mem_t        wr_q[$], exp_wr[$];
  logic [14:0] rd_q[$], exp_rd[$];
  logic [15:0] rom  [0:32767];
  logic [15:0] ram  [0:32767];
  logic [15:0] mram [0:32767];
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;

  function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? xx + yy : xx & yy;
    if (c[0]) o = ~o;
    return o;
  endfunction

  // Environment: ALU, A-input mux, ROM and RAM, all answering on the falling edge.
  initial begin : env
    logic [15:0] alu_o;
    bus.instr_valid = 1'b0; bus.instr = 16'h0; bus.mux_out = 16'h0; bus.alu_out = 16'h0;
    bus.alu_zr = 1'b0; bus.alu_ng = 1'b0; bus.inM = 16'h0; bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      alu_o = alu_f(bus.alu_x, bus.alu_y, bus.alu_ctrl);
      bus.alu_out = alu_o;
      bus.alu_zr  = (alu_o == 16'h0);
      bus.alu_ng  = alu_o[15];
      bus.mux_out = bus.mux_sel ? alu_o : bus.ir;
      if (bus.instr_req) begin
        bus.instr_valid = (wait_pct == 0) || ($urandom_range(99) >= wait_pct);
        bus.instr = bus.instr_valid ? rom[bus.instr_addr] : 16'($urandom);
      end else begin
        bus.instr_valid = 1'($urandom);
        bus.instr = 16'($urandom);
      end
      if (bus.readM || bus.writeM) begin
        bus.mem_ack = !ack_block && ((wait_pct == 0) || ($urandom_range(99) >= wait_pct));
        bus.inM = (bus.mem_ack && bus.readM) ? ram[bus.addressM] : 16'($urandom);
      end else begin
        bus.mem_ack = 1'($urandom);
        bus.inM = 16'($urandom);
      end
      if (!reset) begin
        if (bus.writeM) wr_cycles++;
        if (bus.instr_req && bus.instr_valid)
          fetch_q.push_back('{pc: bus.instr_addr, a: bus.addressM, d: bus.alu_x, y: bus.alu_y,
                              ir: bus.ir, cyc: cyc, stalls: stall_cnt});
        else if (bus.instr_req) stall_cnt++;
        if ((bus.readM || bus.writeM) && !bus.mem_ack) stall_cnt++;
        if (bus.writeM && bus.mem_ack) begin
          ram[bus.addressM] = bus.outM;
          wr_q.push_back('{addr: bus.addressM, dat: bus.outM});
        end
        if (bus.readM && bus.mem_ack) rd_q.push_back(bus.addressM);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  // Instruction-level reference: one call executes one whole Hack instruction.
  task automatic model_step(input logic [15:0] ins);
    logic [15:0] y, o, a_old;
    bit jmp;
    if (!ins[15]) begin
      m_a  = ins;
      m_pc = m_pc + 15'd1;
      return;
    end
    a_old = m_a;
    if (ins[12]) begin
      y = mram[a_old[14:0]];
      exp_rd.push_back(a_old[14:0]);
    end else begin
      y = a_old;
    end
    o = alu_f(m_d, y, ins[11:6]);
    jmp = (ins[2] && $signed(o) < 0) || (ins[1] && o == 16'h0) || (ins[0] && $signed(o) > 0);
    if (ins[5]) m_a = o;
    if (ins[4]) m_d = o;
    if (ins[3]) begin
      mram[a_old[14:0]] = o;
      exp_wr.push_back('{addr: a_old[14:0], dat: o});
    end
    m_pc = jmp ? a_old[14:0] : m_pc + 15'd1;
  endtask

  task automatic begin_test();
    @(posedge clk); #2 reset = 1'b1;
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'h0; ram[i] = 16'h0; mram[i] = 16'h0;
    end
  endtask

  task automatic release_reset();
    @(posedge clk); @(posedge clk); #2;
    fetch_q.delete(); wr_q.delete(); rd_q.delete(); wr_cycles = 0;
    reset = 1'b0;
  endtask

  task automatic wait_fetch(input int n, input int budget, output bit timed_out);
    int k = 0;
    while (fetch_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    timed_out = (fetch_q.size() < n);
  endtask

  task automatic test_reset();
    begin_test();
    @(posedge clk); #2;
    n_cmp++; if (bus.instr_req !== 1'b1) begin n_err++; $display("FAIL reset_instr_req: got %b want 1", bus.instr_req); end
    n_cmp++; if ({bus.readM, bus.writeM, bus.mux_sel} !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b want 000", {bus.readM, bus.writeM, bus.mux_sel}); end
    n_cmp++; if (bus.instr_addr !== PC_RST) begin n_err++; $display("FAIL reset_pc: got %h want %h", bus.instr_addr, PC_RST); end
    n_cmp++; if (bus.addressM !== 15'h0 || bus.alu_y !== 16'h0) begin n_err++; $display("FAIL reset_a: got %h/%h want 0", bus.addressM, bus.alu_y); end
    n_cmp++; if (bus.alu_x !== 16'h0) begin n_err++; $display("FAIL reset_d: got %h want 0", bus.alu_x); end
    n_cmp++; if (bus.ir !== 16'h0 || bus.outM !== 16'h0) begin n_err++; $display("FAIL reset_ir_outm: got %h/%h want 0", bus.ir, bus.outM); end
  endtask

  task automatic test_a_then_c();
    bit to;
    begin_test();
    rom[0] = 16'h0005; rom[1] = 16'hEC10;
    release_reset();
    wait_fetch(3, 60, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL a_then_c_timeout: got %0d fetches want 3", fetch_q.size()); return; end
    n_cmp++; if (fetch_q[1].pc !== 15'd1 || fetch_q[1].a !== 15'h5) begin n_err++; $display("FAIL a_instr: got pc %h a %h want 1/5", fetch_q[1].pc, fetch_q[1].a); end
    n_cmp++; if (fetch_q[1].cyc - fetch_q[0].cyc !== 2) begin n_err++; $display("FAIL a_latency: got %0d want 2", fetch_q[1].cyc - fetch_q[0].cyc); end
    n_cmp++; if (fetch_q[2].pc !== 15'd2 || fetch_q[2].d !== 16'h5) begin n_err++; $display("FAIL c_d_eq_a: got pc %h d %h want 2/5", fetch_q[2].pc, fetch_q[2].d); end
    n_cmp++; if (wr_cycles !== 0) begin n_err++; $display("FAIL c_no_write: got %0d writeM cycles want 0", wr_cycles); end
  endtask

  task automatic test_mem_rw();
    bit to;
    begin_test();
    rom[0] = 16'h0010; rom[1] = 16'hFDC8; ram[16'h10] = 16'h1234;
    release_reset();
    wait_fetch(3, 60, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL mem_rw_timeout: got %0d fetches want 3", fetch_q.size()); return; end
    n_cmp++; if (rd_q.size() != 1 || rd_q[0] !== 15'h10) begin n_err++; $display("FAIL mem_read: got %0d reads want 1 at 0010", rd_q.size()); end
    n_cmp++; if (wr_q.size() != 1 || wr_q[0].addr !== 15'h10 || wr_q[0].dat !== 16'h1235) begin n_err++; $display("FAIL mem_write: got %0d writes want 1 of 1235 at 0010", wr_q.size()); end
    n_cmp++; if (fetch_q[2].cyc - fetch_q[1].cyc !== 5) begin n_err++; $display("FAIL mem_rw_latency: got %0d want 5", fetch_q[2].cyc - fetch_q[1].cyc); end
  endtask

  task automatic test_jump();
    bit to;
    begin_test();
    rom[0] = 16'h0042; rom[1] = 16'hEA82;
    release_reset();
    wait_fetch(3, 60, to);
    n_cmp++; if (to || fetch_q[2].pc !== 15'h42) begin n_err++; $display("FAIL jeq_taken: got %0d fetches, pc %h want 0042", fetch_q.size(), to ? 15'h0 : fetch_q[2].pc); end
    begin_test();
    rom[0] = 16'hEFD0; rom[1] = 16'h0042; rom[2] = 16'hE302;
    release_reset();
    wait_fetch(4, 60, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL jeq_nt_timeout: got %0d fetches want 4", fetch_q.size()); return; end
    n_cmp++; if (fetch_q[1].d !== 16'h1) begin n_err++; $display("FAIL d_eq_1: got %h want 0001", fetch_q[1].d); end
    n_cmp++; if (fetch_q[3].pc !== 15'd3) begin n_err++; $display("FAIL jeq_not_taken: got %h want 0003", fetch_q[3].pc); end
  endtask

  task automatic test_wrap_and_am_jump();
    bit to;
    begin_test();
    rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[15'h7FFF] = 16'h0123;
    release_reset();
    wait_fetch(4, 60, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL wrap_timeout: got %0d fetches want 4", fetch_q.size()); return; end
    n_cmp++; if (fetch_q[2].pc !== 15'h7FFF) begin n_err++; $display("FAIL jmp_7fff: got %h want 7fff", fetch_q[2].pc); end
    n_cmp++; if (fetch_q[3].pc !== 15'h0 || fetch_q[3].a !== 15'h123) begin n_err++; $display("FAIL pc_wrap: got pc %h a %h want 0000/0123", fetch_q[3].pc, fetch_q[3].a); end
    begin_test();
    rom[0] = 16'h0020; rom[1] = 16'hFCAF; ram[16'h20] = 16'h0055;
    release_reset();
    wait_fetch(3, 60, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL am_timeout: got %0d fetches want 3", fetch_q.size()); return; end
    n_cmp++; if (fetch_q[2].pc !== 15'h20 || fetch_q[2].a !== 15'h54) begin n_err++; $display("FAIL am_jump: got pc %h a %h want 0020/0054", fetch_q[2].pc, fetch_q[2].a); end
    n_cmp++; if (wr_q.size() != 1 || wr_q[0].addr !== 15'h20 || wr_q[0].dat !== 16'h54) begin n_err++; $display("FAIL am_write: got %0d writes want 1 of 0054 at 0020", wr_q.size()); end
  endtask

  task automatic test_latency();
    bit to;
    int exp_lat[5] = '{2, 3, 4, 4, 5};
    begin_test();
    rom[0] = 16'h0010; rom[1] = 16'hEC10; rom[2] = 16'hFC10; rom[3] = 16'hE308; rom[4] = 16'hFDC8;
    release_reset();
    wait_fetch(6, 80, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL latency_timeout: got %0d fetches want 6", fetch_q.size()); return; end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (fetch_q[i+1].cyc - fetch_q[i].cyc !== exp_lat[i]) begin
        n_err++; $display("FAIL latency_%0d: got %0d want %0d", i, fetch_q[i+1].cyc - fetch_q[i].cyc, exp_lat[i]);
      end
    end
  endtask

  task automatic test_reset_in_wb();
    int k = 0;
    begin_test();
    rom[0] = 16'h0010; rom[1] = 16'hE308;
    ack_block = 1'b1;
    release_reset();
    while (!bus.writeM && k < 50) begin @(posedge clk); #2; k++; end
    n_cmp++; if (bus.writeM !== 1'b1) begin n_err++; $display("FAIL wb_reach: got writeM %b want 1", bus.writeM); end
    @(posedge clk); #2;
    n_cmp++; if (bus.writeM !== 1'b1 || bus.addressM !== 15'h10) begin n_err++; $display("FAIL wb_hold: got writeM %b addr %h want 1/0010", bus.writeM, bus.addressM); end
    reset = 1'b1;
    @(posedge clk); #2;
    n_cmp++; if (bus.writeM !== 1'b0 || bus.readM !== 1'b0) begin n_err++; $display("FAIL wb_reset_strobe: got r%b w%b want 00", bus.readM, bus.writeM); end
    n_cmp++; if (bus.instr_req !== 1'b1 || bus.instr_addr !== PC_RST) begin n_err++; $display("FAIL wb_reset_fetch: got req %b pc %h want 1/%h", bus.instr_req, bus.instr_addr, PC_RST); end
    ack_block = 1'b0;
  endtask

  task automatic test_random();
    localparam int N = 60;
    bit to;
    logic [15:0] prev_ins, ins;
    int exp_dt;
    for (int run = 0; run < 4; run++) begin
      begin_test();
      wait_pct = (run == 0) ? 0 : int'($urandom_range(60, 10));
      for (int i = 0; i < 32768; i++) begin
        if ($urandom_range(1) == 1) rom[i] = {1'b0, 15'($urandom_range(63))};
        else rom[i] = {3'b111, 1'($urandom), 6'($urandom), 3'($urandom), 3'($urandom)};
        ram[i] = 16'($urandom);
        mram[i] = ram[i];
      end
      m_a = 16'h0; m_d = 16'h0; m_pc = PC_RST; prev_ins = 16'h0;
      exp_wr.delete(); exp_rd.delete();
      release_reset();
      wait_fetch(N + 1, N * 60, to);
      n_cmp++; if (to) begin n_err++; $display("FAIL rand%0d_timeout: got %0d fetches want %0d", run, fetch_q.size(), N + 1); continue; end
      for (int i = 0; i <= N; i++) begin
        n_cmp++;
        if (fetch_q[i].pc !== m_pc || fetch_q[i].a !== m_a[14:0] || fetch_q[i].d !== m_d || fetch_q[i].ir !== prev_ins) begin
          n_err++;
          $display("FAIL rand%0d_state_%0d: got pc %h a %h d %h ir %h want pc %h a %h d %h ir %h", run, i,
                   fetch_q[i].pc, fetch_q[i].a, fetch_q[i].d, fetch_q[i].ir, m_pc, m_a[14:0], m_d, prev_ins);
        end
        if (!prev_ins[12]) begin
          n_cmp++;
          if (fetch_q[i].y !== m_a) begin n_err++; $display("FAIL rand%0d_alu_y_%0d: got %h want %h", run, i, fetch_q[i].y, m_a); end
        end
        if (i > 0) begin
          exp_dt = (prev_ins[15] ? 3 + int'(prev_ins[12]) + int'(prev_ins[3]) : 2) + (fetch_q[i].stalls - fetch_q[i-1].stalls);
          n_cmp++;
          if (fetch_q[i].cyc - fetch_q[i-1].cyc !== exp_dt) begin
            n_err++; $display("FAIL rand%0d_cycles_%0d: got %0d want %0d", run, i, fetch_q[i].cyc - fetch_q[i-1].cyc, exp_dt);
          end
        end
        if (i < N) begin
          ins = rom[m_pc];
          model_step(ins);
          prev_ins = ins;
        end
      end
      n_cmp++;
      if (wr_q.size() < exp_wr.size() || rd_q.size() < exp_rd.size()) begin
        n_err++; $display("FAIL rand%0d_mem_count: got %0d wr %0d rd want >= %0d wr %0d rd", run, wr_q.size(), rd_q.size(), exp_wr.size(), exp_rd.size());
        continue;
      end
      foreach (exp_wr[j]) begin
        n_cmp++;
        if (wr_q[j].addr !== exp_wr[j].addr || wr_q[j].dat !== exp_wr[j].dat) begin
          n_err++; $display("FAIL rand%0d_write_%0d: got %h@%h want %h@%h", run, j, wr_q[j].dat, wr_q[j].addr, exp_wr[j].dat, exp_wr[j].addr);
        end
      end
      foreach (exp_rd[j]) begin
        n_cmp++;
        if (rd_q[j] !== exp_rd[j]) begin n_err++; $display("FAIL rand%0d_read_%0d: got %h want %h", run, j, rd_q[j], exp_rd[j]); end
      end
    end
    wait_pct = 0;
  endtask

  initial begin : main
    test_reset();
    test_a_then_c();
    test_mem_rw();
    test_jump();
    test_wrap_and_am_jump();
    test_latency();
    test_reset_in_wb();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
